// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: stall bit positions,
// stall encodings, FSM state encoding and the stall merge helper.
package pipe_ctrl_pkg;

  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  localparam logic [5:0] NoStall = 6'b000000;
  localparam logic [5:0] StallId = 6'b000111;
  localparam logic [5:0] StallEx = 6'b001111;

  // Wide enough for the largest legal divider timeout (255).
  localparam int DIV_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MULTI    = 2'd1,
    ST_DIV_WAIT = 2'd2
  } state_e;

  // An EX hold already freezes PC/IF/ID, so it subsumes an ID request.
  function automatic logic [5:0] merge_stall(input logic sreq_ex, input logic sreq_id);
    logic [5:0] v;
    v = NoStall;
    if (sreq_ex == Stop) begin
      v = StallEx;
    end else if (sreq_id == Stop) begin
      v = StallId;
    end
    return v;
  endfunction

endpackage

// File: rtl/pipe_ctrl_div_timer.sv
// Divider timeout counter: cleared when a divide starts, advanced once per
// waiting cycle, and flags the final permitted wait cycle.
module pipe_ctrl_div_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic                 i_inc,
  output logic                 o_expired,
  output logic [DIV_CNT_W-1:0] o_count
);

  localparam logic [DIV_CNT_W-1:0] LastCount = DIV_CNT_W'(TIMEOUT - 1);

  logic [DIV_CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == LastCount);
  assign o_count   = r_count;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: merges stage stall requests, sequences two-cycle multiply
// ops and the divider handshake with timeout, and counts PC stall cycles.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_TIMEOUT = 40,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             ex_multi_op,
  input  logic             ex_div_op,
  input  logic             ex_div_signed,
  input  logic             div_ready,
  output logic [5:0]       stall,
  output logic             ex_cycle,
  output logic             div_start,
  output logic             div_signed,
  output logic             ex_div_done,
  output logic             div_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [1:0]       dbg_state
);

  // Divider handshake: div_start is a level held for the whole operation.
  // The divider's div_ready is only honoured in DIV_WAIT; the cycle it is
  // seen, EX captures the result (ex_div_done) and the EX hold is released.

  state_e r_state;
  state_e w_next_state;

  logic                 w_sreq_ex;
  logic                 w_div_start;
  logic                 w_ex_cycle;
  logic                 w_ex_div_done;
  logic                 w_div_err;
  logic                 w_tmr_clr;
  logic                 w_tmr_inc;
  logic                 w_tmr_expired;
  logic [DIV_CNT_W-1:0] w_tmr_count;
  logic [5:0]           w_stall;

  logic [CNT_W-1:0] r_stall_cycles;

  pipe_ctrl_div_timer #(
    .TIMEOUT (DIV_TIMEOUT)
  ) u_div_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_tmr_clr),
    .i_inc     (w_tmr_inc),
    .o_expired (w_tmr_expired),
    .o_count   (w_tmr_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_sreq_ex     = NoStop;
    w_div_start   = 1'b0;
    w_ex_cycle    = 1'b0;
    w_ex_div_done = 1'b0;
    w_div_err     = 1'b0;
    w_tmr_clr     = 1'b0;
    w_tmr_inc     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ex_div_op) begin
          w_sreq_ex    = Stop;
          w_div_start  = 1'b1;
          w_tmr_clr    = 1'b1;
          w_next_state = ST_DIV_WAIT;
        end else if (ex_multi_op) begin
          w_sreq_ex    = Stop;
          w_next_state = ST_MULTI;
        end
      end
      ST_MULTI: begin
        w_ex_cycle   = 1'b1;
        w_next_state = ST_IDLE;
      end
      ST_DIV_WAIT: begin
        if (div_ready) begin
          w_div_start   = 1'b1;
          w_ex_div_done = 1'b1;
          w_next_state  = ST_IDLE;
        end else if (w_tmr_expired) begin
          // Abandon the divide; the exception path recovers the EX result.
          w_div_err    = 1'b1;
          w_next_state = ST_IDLE;
        end else begin
          w_div_start = 1'b1;
          w_sreq_ex   = Stop;
          w_tmr_inc   = 1'b1;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  assign w_stall = merge_stall(w_sreq_ex, stallreq_id);

  // Outputs are forced low for the whole reset assertion, independent of inputs.
  assign stall       = rst ? NoStall : w_stall;
  assign ex_cycle    = ~rst & w_ex_cycle;
  assign div_start   = ~rst & w_div_start;
  assign div_signed  = ~rst & w_div_start & ex_div_signed;
  assign ex_div_done = ~rst & w_ex_div_done;
  assign div_err     = ~rst & w_div_err;
  assign dbg_state   = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (stall[STALL_PC] && (r_stall_cycles != {CNT_W{1'b1}})) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign stall_cycles = r_stall_cycles;

endmodule
